mrd_pkt_sched: RTL and testbench

MRD_PKT_SCHED -- requirements
Module: mrd_pkt_sched

---
 rtl/mrd_mem_pkt.sv | 26 ++
 rtl/mrd_factor_step.sv | 49 ++++
 rtl/mrd_pkt_sched.sv | 179 +++++++++++++++++
 tb/tb_mrd_pkt_sched.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mrd_mem_pkt.sv
// -----------------------------------------------------------------------------
// mrd_mem_pkt
// Shared definitions for the DFT packet scheduler:
//   state_e     - scheduler FSM states
//   MAX_FACTORS - most radix factors one packet may carry (eng_nf entries)
//   RADIX_*     - 3-bit codes written into eng_nf (the code is the radix value;
//                 RADIX_NONE marks an unused entry)
// -----------------------------------------------------------------------------
package mrd_mem_pkt;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FACT  = 2'd1,
    S_START = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  localparam int MAX_FACTORS = 6;

  localparam logic [2:0] RADIX_NONE = 3'd0;
  localparam logic [2:0] RADIX_2    = 3'd2;
  localparam logic [2:0] RADIX_3    = 3'd3;
  localparam logic [2:0] RADIX_4    = 3'd4;
  localparam logic [2:0] RADIX_5    = 3'd5;

endpackage

// File: rtl/mrd_factor_step.sv
// -----------------------------------------------------------------------------
// mrd_factor_step
// One combinational factorisation step on the running remainder. Radices are
// tried in the order 4, 2, 3, 5; the first exact divisor wins.
//   rem    in  12  current remainder
//   factor out  3  chosen radix code (RADIX_NONE when none applies)
//   quot   out 12  rem / factor (exact), rem otherwise
//   is_one out  1  remainder is fully factored
//   err    out  1  remainder is 0 or has no factor among 2/3/4/5
// -----------------------------------------------------------------------------
module mrd_factor_step
  import mrd_mem_pkt::*;
(
  input  logic [11:0] rem,
  output logic [2:0]  factor,
  output logic [11:0] quot,
  output logic        is_one,
  output logic        err
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    factor = RADIX_NONE;
    quot   = rem;
    is_one = (rem == 12'd1);
    err    = 1'b0;
    if (rem == 12'd0) begin
      err = 1'b1;
    end else if (!is_one) begin
      if (rem[1:0] == 2'b00) begin
        factor = RADIX_4;
        quot   = rem >> 2;
      end else if (rem[0] == 1'b0) begin
        factor = RADIX_2;
        quot   = rem >> 1;
      end else if ((rem % 12'd3) == 12'd0) begin
        factor = RADIX_3;
        quot   = rem / 12'd3;
      end else if ((rem % 12'd5) == 12'd0) begin
        factor = RADIX_5;
        quot   = rem / 12'd5;
      end else begin
        err = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mrd_pkt_sched.sv
// -----------------------------------------------------------------------------
// mrd_pkt_sched
// Round-robin scheduler for two DFT packet requesters. The granted packet's
// size is factored into radix 2/3/4/5 stages (one per cycle), then the DFT
// memory engine is launched and the scheduler waits for it to finish.
//
// Optional feature: define MRD_SCHED_WDOG_EN to abort a RUN that lasts
// WDOG_CYCLES cycles without eng_done (wdog_err pulse).
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   req[1:0]       per-requester request, held until granted
//   req_dftpts     per-requester DFT size, requester i at [12*i +: 12]
//   grant[1:0]     one-hot grant pulse (on launch or on a size error)
//   eng_start      engine launch pulse
//   eng_dftpts     latched size of the granted packet
//   eng_nof        number of radix factors
//   eng_nf         radix factors, Nf[i] at [3*i +: 3], unused entries 0
//   eng_done       engine packet-complete pulse, honoured only in RUN
//   busy           high whenever the FSM is not IDLE
//   cfg_err        pulse when the size cannot be factored
//   wdog_err       pulse on watchdog abort (always 0 without the feature)
// -----------------------------------------------------------------------------
module mrd_pkt_sched
  import mrd_mem_pkt::*;
#(
  parameter int unsigned WDOG_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [23:0] req_dftpts,
  output logic [1:0]  grant,
  output logic        eng_start,
  output logic [11:0] eng_dftpts,
  output logic [2:0]  eng_nof,
  output logic [17:0] eng_nf,
  input  logic        eng_done,
  output logic        busy,
  output logic        cfg_err,
  output logic        wdog_err
);

  if (WDOG_CYCLES < 1) begin : g_wdog_range
    $error("WDOG_CYCLES must be at least 1");
  end

  state_e      state;
  logic        rr_ptr;      // requester with priority at the next arbitration
  logic        sel;         // requester being served
  logic [11:0] rem;         // part of the size not yet factored

  logic [2:0]  step_factor;
  logic [11:0] step_quot;
  logic        step_is_one;
  logic        step_err;
  logic        step_bad;
  logic [1:0]  req_avail;
  logic        pick;

  mrd_factor_step u_step (
    .rem    (rem),
    .factor (step_factor),
    .quot   (step_quot),
    .is_one (step_is_one),
    .err    (step_err)
  );

  // A requester whose grant is showing this cycle has not yet had a chance
  // to drop req, so it must not be picked again.
  assign req_avail = req & ~grant;

  // With priority on 1, take 1 if it asks, else 0; with priority on 0, take 0
  // if it asks, else 1.
  assign pick = rr_ptr ? req_avail[1] : ~req_avail[0];

  // A size of 1 gives no factors, and a seventh factor does not fit.
  assign step_bad = step_err
                  | (step_is_one && (eng_nof == 3'd0))
                  | (!step_is_one && (eng_nof == 3'(MAX_FACTORS)));

`ifdef MRD_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt;
`else
  assign wdog_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rr_ptr     <= 1'b0;
      sel        <= 1'b0;
      rem        <= '0;
      grant      <= '0;
      eng_start  <= 1'b0;
      eng_dftpts <= '0;
      eng_nof    <= '0;
      eng_nf     <= '0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
`ifdef MRD_SCHED_WDOG_EN
      wdog_err   <= 1'b0;
      wdog_cnt   <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register sees the pre-edge values; pulse outputs default low here and
      // are raised for a single cycle below.
      grant     <= '0;
      eng_start <= 1'b0;
      cfg_err   <= 1'b0;
`ifdef MRD_SCHED_WDOG_EN
      wdog_err  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (|req_avail) begin
            sel        <= pick;
            rem        <= pick ? req_dftpts[23:12] : req_dftpts[11:0];
            eng_dftpts <= pick ? req_dftpts[23:12] : req_dftpts[11:0];
            eng_nf     <= '0;
            eng_nof    <= '0;
            busy       <= 1'b1;
            state      <= S_FACT;
          end
        end

        S_FACT: begin
          if (step_bad) begin
            grant   <= sel ? 2'b10 : 2'b01;
            cfg_err <= 1'b1;
            rr_ptr  <= ~sel;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else if (step_is_one) begin
            // Registered so grant and eng_start are visible during START.
            grant     <= sel ? 2'b10 : 2'b01;
            eng_start <= 1'b1;
            rr_ptr    <= ~sel;
            state     <= S_START;
          end else begin
            for (int i = 0; i < MAX_FACTORS; i++) begin
              if (eng_nof == 3'(i)) eng_nf[3*i +: 3] <= step_factor;
            end
            eng_nof <= eng_nof + 3'd1;
            rem     <= step_quot;
          end
        end

        S_START: begin
`ifdef MRD_SCHED_WDOG_EN
          wdog_cnt <= '0;
`endif
          state <= S_RUN;
        end

        S_RUN: begin
          if (eng_done) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
`ifdef MRD_SCHED_WDOG_EN
          else if (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
            wdog_err <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mrd_pkt_sched.sv
// -----------------------------------------------------------------------------
// tb_mrd_pkt_sched
// Directed bench for mrd_pkt_sched. Each issued packet pushes its expected
// grant/factorisation onto a scoreboard; a negedge monitor pops and compares
// whenever the DUT raises a grant. Watchdog steps run only when
// MRD_SCHED_WDOG_EN is defined.
// -----------------------------------------------------------------------------
module tb_mrd_pkt_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [23:0] req_dftpts;
  logic [1:0]  grant;
  logic        eng_start;
  logic [11:0] eng_dftpts;
  logic [2:0]  eng_nof;
  logic [17:0] eng_nf;
  logic        eng_done;
  logic        busy;
  logic        cfg_err;
  logic        wdog_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [1:0]  grant;
    logic        err;
    logic [11:0] dftpts;
    logic [2:0]  nof;
    logic [17:0] nf;
    int          lat_cyc;   // relative latency on push, absolute cycle (or -1) once queued
  } exp_t;

  exp_t sb[$];

  mrd_pkt_sched #(.WDOG_CYCLES(50)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_dftpts (req_dftpts),
    .grant      (grant),
    .eng_start  (eng_start),
    .eng_dftpts (eng_dftpts),
    .eng_nof    (eng_nof),
    .eng_nf     (eng_nf),
    .eng_done   (eng_done),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .wdog_err   (wdog_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference factorisation: radix 4, then 2, 3, 5; at most six factors.
  function automatic exp_t model(input logic [1:0] g, input logic [11:0] n);
    exp_t e;
    int   r;
    int   k;
    int   f;
    e.grant  = g;
    e.err    = 1'b0;
    e.dftpts = n;
    e.nf     = '0;
    r        = int'(n);
    k        = 0;
    if (r < 2) e.err = 1'b1;
    while (!e.err && r != 1) begin
      if (r % 4 == 0)      f = 4;
      else if (r % 2 == 0) f = 2;
      else if (r % 3 == 0) f = 3;
      else if (r % 5 == 0) f = 5;
      else                 f = 0;
      if (f == 0 || k == 6) e.err = 1'b1;
      else begin
        e.nf[3*k +: 3] = 3'(f);
        r = r / f;
        k++;
      end
    end
    e.nof     = 3'(k);
    e.lat_cyc = k + 2;
    return e;
  endfunction

  function automatic exp_t mk(input logic [1:0] g, input logic err, input logic [11:0] n,
                              input logic [2:0] nof, input logic [17:0] nf, input int lat);
    exp_t e;
    e.grant = g; e.err = err; e.dftpts = n; e.nof = nof; e.nf = nf; e.lat_cyc = lat;
    return e;
  endfunction

  task automatic issue(input int r, input exp_t e, input bit chk_lat);
    if (r == 0) req_dftpts[11:0] = e.dftpts;
    else        req_dftpts[23:12] = e.dftpts;
    req[r] = 1'b1;
    e.lat_cyc = chk_lat ? cyc + e.lat_cyc : -1;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = (grant != 2'b00);
    end
    check("grant_seen", 32'(seen), 32'd1);
  endtask

  task automatic finish_pkt(input int delay);
    repeat (delay) tick();
    check("busy_run", 32'(busy), 32'd1);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("busy_drop", 32'(busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"},     32'(grant),      32'd0);
    check({tag, "_start"},     32'(eng_start),  32'd0);
    check({tag, "_busy"},      32'(busy),       32'd0);
    check({tag, "_cfg_err"},   32'(cfg_err),    32'd0);
    check({tag, "_wdog_err"},  32'(wdog_err),   32'd0);
    check({tag, "_nof"},       32'(eng_nof),    32'd0);
    check({tag, "_nf"},        32'(eng_nf),     32'd0);
    check({tag, "_dftpts"},    32'(eng_dftpts), 32'd0);
  endtask

  // Scoreboard monitor: every grant must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (grant != 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_grant", 32'(grant), 32'd0);
      end else begin
        e = sb.pop_front();
        check("grant",     32'(grant),     32'(e.grant));
        check("cfg_err",   32'(cfg_err),   32'(e.err));
        check("eng_start", 32'(eng_start), 32'(!e.err));
        check("busy",      32'(busy),      32'(!e.err));
        check("dftpts",    32'(eng_dftpts), 32'(e.dftpts));
        if (!e.err) begin
          check("nof", 32'(eng_nof), 32'(e.nof));
          check("nf",  32'(eng_nf),  32'(e.nf));
        end
        if (e.lat_cyc >= 0) check("latency", 32'(cyc), 32'(e.lat_cyc));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n      = 1'b0;
    req        = 2'b00;
    req_dftpts = '0;
    eng_done   = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Size 12: factors {4,3}, launch four cycles after the sample.
    issue(0, mk(2'b01, 1'b0, 12'd12, 3'd2, {12'd0, 3'd3, 3'd4}, 4), 1'b1);
    wait_grant(20);
    req = 2'b00;
    repeat (5) tick();
    check("run_hold_nof",    32'(eng_nof),    32'd2);
    check("run_hold_dftpts", 32'(eng_dftpts), 32'd12);
    check("run_hold_nf",     32'(eng_nf),     32'({12'd0, 3'd3, 3'd4}));
    finish_pkt(3);

    // Size 1200: factors {4,4,3,5,5}.
    issue(0, mk(2'b01, 1'b0, 12'd1200, 3'd5, {3'd0, 3'd5, 3'd5, 3'd3, 3'd4, 3'd4}, 7), 1'b1);
    wait_grant(20);
    req = 2'b00;
    finish_pkt(10);

    // Unfactorable sizes and factor-count boundaries.
    issue(1, mk(2'b10, 1'b1, 12'd7, 3'd0, 18'd0, 2), 1'b1);
    wait_grant(20);
    req = 2'b00;
    tick();
    check("idle_after_err7", 32'(busy), 32'd0);
    issue(0, mk(2'b01, 1'b1, 12'd0, 3'd0, 18'd0, 2), 1'b1);
    wait_grant(20);
    req = 2'b00;
    tick();
    check("idle_after_err0", 32'(busy), 32'd0);
    issue(1, model(2'b10, 12'd1), 1'b1);
    wait_grant(20);
    req = 2'b00;
    issue(0, model(2'b01, 12'd3888), 1'b1);   // needs a seventh factor
    wait_grant(20);
    req = 2'b00;
    issue(1, model(2'b10, 12'd2048), 1'b1);   // exactly six factors
    wait_grant(20);
    req = 2'b00;
    finish_pkt(2);
    issue(0, model(2'b01, 12'd2), 1'b1);
    wait_grant(20);
    req = 2'b00;
    finish_pkt(2);
    issue(1, model(2'b10, 12'd60), 1'b1);
    wait_grant(20);
    req = 2'b00;
    finish_pkt(2);

    // Both requesters held: grants alternate 01, 10, 01.
    issue(0, model(2'b01, 12'd12), 1'b1);
    issue(1, model(2'b10, 12'd20), 1'b0);
    sb.push_back(mk(2'b01, 1'b0, 12'd12, 3'd2, {12'd0, 3'd3, 3'd4}, -1));
    wait_grant(20);
    finish_pkt(100);
    tick();
    check("fact_after_idle1", 32'(busy), 32'd1);
    wait_grant(20);
    finish_pkt(100);
    tick();
    check("fact_after_idle2", 32'(busy), 32'd1);
    wait_grant(20);
    req = 2'b00;
    finish_pkt(100);

    // Reset during FACT: packet dropped, priority back to requester 0.
    req_dftpts[11:0] = 12'd1200;
    req = 2'b01;
    tick();
    tick();
    rst_n = 1'b0;
    req   = 2'b00;
    tick();
    check_zero("rst_fact");
    rst_n = 1'b1;
    tick();
    issue(0, model(2'b01, 12'd12), 1'b1);
    issue(1, model(2'b10, 12'd20), 1'b0);
    void'(sb.pop_back());    // requester 1 withdraws before being selected
    wait_grant(20);
    req = 2'b00;
    finish_pkt(3);

    // Reset during RUN of a requester-0 packet.
    issue(0, model(2'b01, 12'd20), 1'b1);
    wait_grant(20);
    req = 2'b00;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check_zero("rst_run");
    rst_n = 1'b1;
    tick();
    issue(0, model(2'b01, 12'd12), 1'b1);
    issue(1, model(2'b10, 12'd20), 1'b0);
    void'(sb.pop_back());
    wait_grant(20);
    req = 2'b00;
    finish_pkt(3);

    // eng_done while idle is ignored.
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    tick();
    check("done_idle_busy", 32'(busy), 32'd0);

`ifdef MRD_SCHED_WDOG_EN
    begin : wdog_steps
      int s;
      int wcyc;
      bit seen;
      issue(0, model(2'b01, 12'd12), 1'b1);
      wait_grant(20);
      req  = 2'b00;
      s    = cyc;
      seen = 1'b0;
      wcyc = -1;
      for (int i = 0; i < 70 && !seen; i++) begin
        tick();
        seen = wdog_err;
        if (seen) wcyc = cyc;
      end
      check("wdog_seen",  32'(seen), 32'd1);
      check("wdog_cycle", 32'(wcyc), 32'(s + 51));
      check("wdog_idle",  32'(busy), 32'd0);
      issue(0, model(2'b01, 12'd12), 1'b1);
      wait_grant(20);
      req = 2'b00;
      repeat (50) tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("wdog_done_wins", 32'(wdog_err), 32'd0);
      check("wdog_done_idle", 32'(busy),     32'd0);
      tick();
      check("wdog_done_late", 32'(wdog_err), 32'd0);
    end
`endif

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
